// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide at one bit per
// cycle, plus direct mthi/mtlo writes into the HI/LO registers.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [2:0] OpMultu = 3'b000;
    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpDivu  = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_div_q, zero_div_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    // Multiply: shift_q = multiplicand, work_q = multiplier, acc_q = product.
    // Divide:   shift_q = divisor, work_q = dividend/quotient, acc_q[WIDTH-1:0] = remainder.
    logic [2*WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               op_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     rem_sh;

    assign op_signed = op[0];
    assign mag_a     = (op_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign mag_b     = (op_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    assign rem_sh    = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        zero_div_d = zero_div_q;
        a_raw_d    = a_raw_q;
        shift_d    = shift_q;
        work_d     = work_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        OpMultu, OpMult, OpDivu, OpDiv: begin
                            is_div_d   = op[1];
                            neg_res_d  = op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                            neg_rem_d  = op_signed && operand_a[WIDTH-1];
                            zero_div_d = (operand_b == '0);
                            a_raw_d    = operand_a;
                            acc_d      = '0;
                            cnt_d      = CntW'(WIDTH - 1);
                            dbz_d      = 1'b0;
                            state_d    = StCalc;
                            if (op[1]) begin
                                shift_d = {{WIDTH{1'b0}}, mag_b};
                                work_d  = mag_a;
                            end else begin
                                shift_d = {{WIDTH{1'b0}}, mag_a};
                                work_d  = mag_b;
                            end
                        end
                        OpMthi: begin
                            hi_d   = operand_a;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        OpMtlo: begin
                            lo_d   = operand_a;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    // Restoring step: bring down the next dividend bit, subtract if it fits.
                    if (rem_sh >= {1'b0, shift_q[WIDTH-1:0]}) begin
                        acc_d  = {{WIDTH{1'b0}}, WIDTH'(rem_sh - {1'b0, shift_q[WIDTH-1:0]})};
                        work_d = {work_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
                        work_d = {work_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (work_q[0]) begin
                        acc_d = acc_q + shift_q;
                    end
                    shift_d = shift_q << 1;
                    work_d  = work_q >> 1;
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end else if (zero_div_q) begin
                    hi_d  = a_raw_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    // Most-negative / -1 wraps naturally through the two's-complement negate.
                    lo_d = neg_res_q ? -work_q : work_q;
                    hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_div_q <= 1'b0;
            a_raw_q    <= '0;
            shift_q    <= '0;
            work_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            zero_div_q <= zero_div_d;
            a_raw_q    <= a_raw_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table driven through a scoreboard queue, plus hand-written
// sequences for no-op, start-while-busy and reset-mid-operation.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[12];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
        exp_t e;
        int   n;
        @(negedge clock);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        // Scramble inputs after the accept edge; the latched operands must be used.
        start     = 1'b0;
        op        = 3'b010;
        operand_a = $urandom;
        operand_b = $urandom;
        e.hi  = ehi;
        e.lo  = elo;
        e.dbz = edbz;
        e.due = cyc + (o[2] ? 0 : int'(W) + 1);
        exp_q.push_back(e);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!busy) break;
            n++;
            start = (n == 3);
        end
        start = 1'b0;
        check("busy_cycles", 64'(n), o[2] ? 64'd0 : 64'(W + 1));
        @(negedge clock);
        check("done_seen", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time 100000");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{3'b010, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{3'b101, 32'h00000012, 32'h00000000, 32'h00000007, 32'h00000012, 1'b0};
        vecs[6]  = '{3'b010, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[7]  = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{3'b100, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[10] = '{3'b011, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{3'b000, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0};

        reset     = 1'b1;
        start     = 1'b0;
        op        = 3'b000;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
        end

        // No-op code: nothing starts and HI/LO hold.
        @(negedge clock);
        start     = 1'b1;
        op        = 3'b110;
        operand_a = 32'hAAAA5555;
        @(negedge clock);
        start = 1'b0;
        check("noop_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        check("noop_hi", 64'(hi), 64'h12);
        check("noop_lo", 64'(lo), 64'h34567800);

        // Reset in the middle of a multiply, with a stray divu start while busy.
        @(negedge clock);
        start     = 1'b1;
        op        = 3'b000;
        operand_a = 32'd3;
        operand_b = 32'd4;
        @(negedge clock);
        start = 1'b0;
        begin
            exp_t e;
            e.hi  = 32'd0;
            e.lo  = 32'd12;
            e.dbz = 1'b0;
            e.due = 0;
            exp_q.push_back(e);
        end
        check("seq_busy_after_start", 64'(busy), 64'd1);
        repeat (4) @(negedge clock);
        start     = 1'b1;
        op        = 3'b010;
        operand_a = 32'd100;
        operand_b = 32'd9;
        @(negedge clock);
        start = 1'b0;
        check("seq_busy_ignored_start", 64'(busy), 64'd1);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        check("seq_reset_busy", 64'(busy), 64'd0);
        check("seq_reset_hi", 64'(hi), 64'd0);
        check("seq_reset_lo", 64'(lo), 64'd0);
        check("seq_reset_done", 64'(done), 64'd0);
        repeat (40) @(negedge clock);
        check("seq_idle_after_reset", 64'(busy), 64'd0);

        run_op(3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
